// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-panel controller for manual time setting.
// Debounces MODE/INC, steps RUN -> SET_MIN -> SET_HOUR -> RUN and issues
// single-clock minute/hour increment pulses with auto-repeat, idle timeout
// and a blink enable for the field being edited.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100,
  parameter int unsigned TIMEOUT_TICKS  = 10000,
  parameter int unsigned BLINK_TICKS    = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       is_manual_set,
  output logic       min_set,
  output logic       hour_set,
  output logic [1:0] field_sel,
  output logic       blink_on
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_MIN  = 2'b01;
  localparam logic [1:0] ST_HOUR = 2'b10;

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_FULL  = HW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [IW-1:0] IDLE_FULL  = IW'(TIMEOUT_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] pre_q;
  logic          tick_s;
  logic [1:0]    sync1_q, sync2_q;
  logic [DW-1:0] deb_cnt_q [2];
  logic [1:0]    deb_q, deb_prev_q;
  logic          p_mode_s, p_inc_s;
  logic [1:0]    state_q, state_d;
  logic          in_set_s, state_chg_s, timeout_s;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;
  logic          hold_ok_s, rep_fire_s, inc_block_q, inc_fire_s;
  logic [IW-1:0] idle_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q, min_set_q, hour_set_q, ism_q;

  assign tick_s      = (pre_q == PRE_LAST);
  assign p_mode_s    = deb_q[0] & ~deb_prev_q[0];
  assign p_inc_s     = deb_q[1] & ~deb_prev_q[1];
  assign in_set_s    = (state_q != ST_RUN);
  assign state_chg_s = (state_d != state_q);
  // A held INC that survived a mode change never repeats in the new field.
  assign hold_ok_s   = in_set_s & deb_q[1] & ~inc_block_q;
  // An increment (press or repeat) counts as activity and beats the timeout.
  assign timeout_s   = in_set_s & (idle_q == IDLE_FULL) & ~p_inc_s & ~rep_fire_s;
  // A mode press in the same clock swallows any increment.
  assign inc_fire_s  = in_set_s & ~p_mode_s & (p_inc_s | rep_fire_s);

  // Prescaler producing the one-clock internal tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else if (tick_s) pre_q <= '0;
    else pre_q <= pre_q + PW'(1);
  end

  // Two-flop synchronizers; bit 0 = MODE, bit 1 = INC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {key_inc, key_mode};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level follows the input after DEBOUNCE_TICKS mismatching ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= '0;
      deb_q <= 2'b00;
    end else if (tick_s) begin
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (deb_cnt_q[k] == DEB_LAST) begin
            deb_q[k]     <= sync2_q[k];
            deb_cnt_q[k] <= '0;
          end else begin
            deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
          end
        end else begin
          deb_cnt_q[k] <= '0;
        end
      end
    end
  end

  // Previous debounced level for rising-edge press detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deb_prev_q <= 2'b00;
    else deb_prev_q <= deb_q;
  end

  // Mode FSM next state; a mode press outranks the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (p_mode_s) state_d = ST_MIN;
        else state_d = ST_RUN;
      end
      ST_MIN: begin
        if (p_mode_s) state_d = ST_HOUR;
        else if (timeout_s) state_d = ST_RUN;
        else state_d = ST_MIN;
      end
      ST_HOUR: begin
        if (p_mode_s || timeout_s) state_d = ST_RUN;
        else state_d = ST_HOUR;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Repeat decision: first pulse at REPEAT_DELAY, then every REPEAT_RATE.
  always_comb begin
    rep_fire_s = 1'b0;
    if (hold_ok_s && tick_s) begin
      if (hold_q == HOLD_LAST) rep_fire_s = 1'b1;
      else if ((hold_q == HOLD_FULL) && (rep_q == RATE_LAST)) rep_fire_s = 1'b1;
      else rep_fire_s = 1'b0;
    end else begin
      rep_fire_s = 1'b0;
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      ism_q      <= 1'b0;
      min_set_q  <= 1'b0;
      hour_set_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ism_q      <= (state_d != ST_RUN);
      min_set_q  <= inc_fire_s & (state_q == ST_MIN);
      hour_set_q <= inc_fire_s & (state_q == ST_HOUR);
    end
  end

  // Hold / repeat counters; cleared on release, block or state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (!hold_ok_s || state_chg_s) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (tick_s) begin
      if (hold_q != HOLD_FULL) hold_q <= hold_q + HW'(1);
      else if (rep_q == RATE_LAST) rep_q <= '0;
      else rep_q <= rep_q + RW'(1);
    end else begin
      hold_q <= hold_q;
      rep_q  <= rep_q;
    end
  end

  // Block INC that is still held when the mode changes, until released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inc_block_q <= 1'b0;
    else if (state_chg_s && deb_q[1]) inc_block_q <= 1'b1;
    else if (!deb_q[1]) inc_block_q <= 1'b0;
    else inc_block_q <= inc_block_q;
  end

  // Idle counter for the SET-state timeout; saturates at TIMEOUT_TICKS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else if (!in_set_s || state_chg_s || p_mode_s || p_inc_s || rep_fire_s) idle_q <= '0;
    else if (tick_s && (idle_q != IDLE_FULL)) idle_q <= idle_q + IW'(1);
    else idle_q <= idle_q;
  end

  // Blink phase: restarts at 0 on every state change, forced low in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_chg_s || !in_set_s) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (tick_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_q <= blink_cnt_q;
      blink_q     <= blink_q;
    end
  end

  assign is_manual_set = ism_q;
  assign min_set       = min_set_q;
  assign hour_set      = hour_set_q;
  assign field_sel     = state_q;
  assign blink_on      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (small tick parameters).
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       is_manual_set, min_set, hour_set, blink_on;
  logic [1:0] field_sel;

  int checks = 0;
  int errors = 0;
  int min_cnt = 0;
  int hour_cnt = 0;
  int viol = 0;
  logic min_prev = 1'b0;
  logic hour_prev = 1'b0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(10),
    .REPEAT_RATE(4), .TIMEOUT_TICKS(50), .BLINK_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .is_manual_set(is_manual_set), .min_set(min_set), .hour_set(hour_set),
    .field_sel(field_sel), .blink_on(blink_on)
  );

  // Pulse monitor: counts pulses, flags overlap, pulses in RUN and wide pulses.
  always @(negedge clk) begin
    if (!rst) begin
      min_prev = 1'b0;
      hour_prev = 1'b0;
    end else begin
      if (min_set === 1'b1) min_cnt++;
      if (hour_set === 1'b1) hour_cnt++;
      if (min_set && hour_set) viol++;
      if ((min_set || hour_set) && field_sel == 2'b00) viol++;
      if (min_set && min_prev) viol++;
      if (hour_set && hour_prev) viol++;
      min_prev = min_set;
      hour_prev = hour_set;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_field(input logic [1:0] exp, input int max, input string tag, output int el);
    el = 0;
    while (field_sel !== exp && el < max) begin
      step(1);
      el++;
    end
    chk(tag, field_sel, exp);
  endtask

  task automatic press_mode();
    key_mode = 1'b1; step(30); key_mode = 1'b0; step(30);
  endtask

  task automatic press_inc();
    key_inc = 1'b1; step(30); key_inc = 1'b0; step(30);
  endtask

  initial begin
    int el, flag, m0, h0, n, t1, t7, c, n_tog, t_run;
    int t_tog [3];
    logic prev_blink;

    // Reset and idle
    step(10);
    chk("rst_field", field_sel, 2'b00);
    chk("rst_ism", is_manual_set, 1'b0);
    chk("rst_min", min_set, 1'b0);
    chk("rst_hour", hour_set, 1'b0);
    chk("rst_blink", blink_on, 1'b0);
    rst = 1'b1;
    flag = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (field_sel != 2'b00 || is_manual_set || min_set || hour_set || blink_on) flag = 1;
    end
    chk("idle_quiet", flag, 0);

    // Debounce: bouncing MODE must not change state
    flag = 0;
    for (int i = 0; i < 40; i++) begin
      key_mode = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      step(1);
      if (field_sel != 2'b00) flag = 1;
    end
    key_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (field_sel != 2'b00) flag = 1;
    end
    chk("bounce_no_change", flag, 0);
    key_mode = 1'b1;
    wait_field(2'b01, 40, "clean_press_field", el);
    chk_rng("clean_press_latency", el, 10, 17);
    chk("clean_press_ism", is_manual_set, 1'b1);
    key_mode = 1'b0;
    step(30);

    // Mode cycle and single increments
    m0 = min_cnt; h0 = hour_cnt;
    press_inc();
    chk("min_inc_count", min_cnt - m0, 1);
    chk("min_inc_no_hour", hour_cnt - h0, 0);
    press_mode();
    chk("set_hour_field", field_sel, 2'b10);
    chk("set_hour_ism", is_manual_set, 1'b1);
    m0 = min_cnt; h0 = hour_cnt;
    press_inc();
    chk("hour_inc_count", hour_cnt - h0, 1);
    chk("hour_inc_no_min", min_cnt - m0, 0);
    press_mode();
    chk("back_run_field", field_sel, 2'b00);
    chk("back_run_ism", is_manual_set, 1'b0);
    m0 = min_cnt; h0 = hour_cnt;
    press_inc();
    chk("run_inc_ignored", (min_cnt - m0) + (hour_cnt - h0), 0);

    // Auto-repeat in SET_MIN
    press_mode();
    chk("repeat_field", field_sel, 2'b01);
    m0 = min_cnt; h0 = hour_cnt;
    n = 0; t1 = 0; t7 = 0;
    key_inc = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (min_set === 1'b1) begin
        n++;
        if (n == 1) t1 = i;
        if (n == 7) begin
          t7 = i;
          break;
        end
      end
    end
    key_inc = 1'b0;
    chk("repeat_reached7", n, 7);
    chk_rng("repeat_span", t7 - t1, 112, 124);
    step(100);
    chk("repeat_total", min_cnt - m0, 7);
    chk("repeat_no_hour", hour_cnt - h0, 0);

    // Timeout and blink in SET_HOUR
    key_mode = 1'b1;
    wait_field(2'b10, 40, "to_hour_field", el);
    key_mode = 1'b0;
    chk("blink_entry", blink_on, 1'b0);
    prev_blink = blink_on;
    n_tog = 0; t_run = 0;
    t_tog[0] = 0; t_tog[1] = 0; t_tog[2] = 0;
    for (c = 1; c <= 260; c++) begin
      step(1);
      if (field_sel == 2'b00) begin
        t_run = c;
        break;
      end
      if (blink_on !== prev_blink) begin
        if (n_tog < 3) t_tog[n_tog] = c;
        n_tog++;
      end
      prev_blink = blink_on;
    end
    chk_rng("blink_first", t_tog[0], 16, 21);
    chk("blink_period1", t_tog[1] - t_tog[0], 20);
    chk("blink_period2", t_tog[2] - t_tog[1], 20);
    chk_rng("timeout_clks", t_run, 196, 204);
    chk("timeout_blink", blink_on, 1'b0);
    chk("timeout_ism", is_manual_set, 1'b0);

    // MODE and INC debounced together in SET_MIN
    press_mode();
    m0 = min_cnt; h0 = hour_cnt;
    key_mode = 1'b1; key_inc = 1'b1;
    step(80);
    key_mode = 1'b0; key_inc = 1'b0;
    step(30);
    chk("simul_field", field_sel, 2'b10);
    chk("simul_no_min", min_cnt - m0, 0);
    chk("simul_no_hour", hour_cnt - h0, 0);

    // INC held across a mode change
    press_mode();
    press_mode();
    chk("held_start_field", field_sel, 2'b01);
    m0 = min_cnt; h0 = hour_cnt;
    key_inc = 1'b1;
    step(20);
    key_mode = 1'b1;
    step(30);
    key_mode = 1'b0;
    step(80);
    key_inc = 1'b0;
    step(30);
    chk("held_field", field_sel, 2'b10);
    chk("held_min_once", min_cnt - m0, 1);
    chk("held_no_hour", hour_cnt - h0, 0);
    press_inc();
    chk("repress_hour", hour_cnt - h0, 1);

    // Reset mid-operation with INC held
    key_inc = 1'b1;
    step(30);
    rst = 1'b0;
    #1;
    chk("midrst_field", field_sel, 2'b00);
    chk("midrst_ism", is_manual_set, 1'b0);
    chk("midrst_min", min_set, 1'b0);
    chk("midrst_hour", hour_set, 1'b0);
    chk("midrst_blink", blink_on, 1'b0);
    step(3);
    key_inc = 1'b0;
    rst = 1'b1;
    step(50);
    chk("post_rst_field", field_sel, 2'b00);
    chk("post_rst_ism", is_manual_set, 1'b0);

    chk("pulse_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
